// File: rtl/gate_tt_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_tt_checker
// Purpose  : Exhaustive truth-table sequencer and response checker for small
//            combinational gate DUTs. After a start request, every input
//            vector 0..2**N_IN-1 is driven onto the DUT in ascending order.
//            Each vector is held for SETTLE cycles, the DUT output is then
//            sampled and compared with a truth table captured at start. The
//            result is a per-vector mismatch mask and a pass flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   N_IN      number of DUT inputs (1..4); NV = 2**N_IN vectors
//   SETTLE    cycles each vector is held before sampling (>= 1)
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset
//   start           in   request a check run (honoured only when idle)
//   expected [NV]   in   expected DUT output, bit k for input vector k
//   stim   [N_IN]   out  DUT input drive, MSB = first DUT input
//   dut_y           in   DUT output under test
//   busy            out  run in progress
//   done            out  one-cycle pulse at run completion
//   pass            out  last completed run had no mismatches
//   fail_mask [NV]  out  bit k set if vector k mismatched in the last run
// Optional feature (macro GATE_TT_FIRST_FAIL_EN):
//   first_fail [N_IN]  out  lowest-numbered mismatching vector (0 on pass)
//   first_fail_vld     out  set when the last run had any mismatch
// ============================================================================
module gate_tt_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        stim,
  input  logic                   dut_y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   fail_mask
`ifdef GATE_TT_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]        first_fail,
  output logic                   first_fail_vld
`endif
);

  localparam int NV    = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic [N_IN-1:0]     idx_q,       idx_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [NV-1:0]       exp_q,       exp_d;
  logic [NV-1:0]       work_mask_q, work_mask_d;
  logic [N_IN-1:0]     stim_q,      stim_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                pass_q,      pass_d;
  logic [NV-1:0]       fail_mask_q, fail_mask_d;
`ifdef GATE_TT_FIRST_FAIL_EN
  logic [N_IN-1:0]     first_fail_q,     first_fail_d;
  logic                first_fail_vld_q, first_fail_vld_d;
  logic [N_IN-1:0]     lowest_fail;

  // Lowest set bit of the working mask; scanning downward lets the lowest
  // index win.
  always_comb begin
    lowest_fail = '0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (work_mask_q[i]) begin
        lowest_fail = N_IN'(i);
      end
    end
  end
`endif

  // All outputs are registered: each state's actions appear on the ports one
  // cycle after the state is occupied. This gives the DUT exactly SETTLE
  // cycles of stable stim before the SAMPLE-state compare edge, and puts the
  // done pulse in the cycle right after DONE.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    work_mask_d = work_mask_q;
    stim_d      = stim_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
`ifdef GATE_TT_FIRST_FAIL_EN
    first_fail_d     = first_fail_q;
    first_fail_vld_d = first_fail_vld_q;
`endif

    case (state_q)
      ST_IDLE: begin
        stim_d = '0;
        busy_d = 1'b0;
        if (start) begin
          // Truth table is frozen here; later changes on expected are ignored.
          exp_d       = expected;
          work_mask_d = '0;
          idx_d       = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = ST_APPLY;
        end
      end

      ST_APPLY: begin
        stim_d = idx_q;
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        stim_d = idx_q;
        busy_d = 1'b1;
        if (dut_y != exp_q[idx_q]) begin
          work_mask_d[idx_q] = 1'b1;
        end
        // Terminate on the last index rather than letting idx wrap.
        if (idx_q == N_IN'(NV - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_APPLY;
        end
      end

      ST_DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        stim_d      = '0;
        fail_mask_d = work_mask_q;
        pass_d      = (work_mask_q == '0);
`ifdef GATE_TT_FIRST_FAIL_EN
        first_fail_d     = lowest_fail;
        first_fail_vld_d = (work_mask_q != '0);
`endif
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      work_mask_q <= '0;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
`ifdef GATE_TT_FIRST_FAIL_EN
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      work_mask_q <= work_mask_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
`ifdef GATE_TT_FIRST_FAIL_EN
      first_fail_q     <= first_fail_d;
      first_fail_vld_q <= first_fail_vld_d;
`endif
    end
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
`ifdef GATE_TT_FIRST_FAIL_EN
  assign first_fail     = first_fail_q;
  assign first_fail_vld = first_fail_vld_q;
`endif

endmodule
`default_nettype wire
